// File: rtl/ps2_pkg.sv
// ==== ps2_pkg : shared PS/2 receiver types and frame constants | rev 1.0 ====
`default_nettype none

package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // A frame is good when data plus parity hold an odd number of ones.
  function automatic logic odd_ones(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_filter.sv
// ==== ps2_filter : line synchronizers, ps2_clk debounce, falling-edge detect | rev 1.0 ====
`default_nettype none

module ps2_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_pulse,
  output logic data_sync
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_ff;
  logic          clk_filt;
  logic [CW-1:0] cnt;
  logic          settle;

  // The filtered level flips on the FILTER_CYCLES-th consecutive differing sample.
  assign settle     = (clk_sync[1] != clk_filt) && (cnt == CW'(FILTER_CYCLES - 1));
  assign fall_pulse = settle & clk_filt;
  assign data_sync  = data_ff[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      data_ff  <= 2'b11;
      clk_filt <= 1'b1;
      cnt      <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      data_ff  <= {data_ff[0], ps2_data};
      if (clk_sync[1] == clk_filt) begin
        cnt <= '0;
      end else if (settle) begin
        clk_filt <= clk_sync[1];
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_rx.sv
// ==== ps2_rx : PS/2 device-to-host byte receiver with error flags and byte FIFO | rev 1.0 ====
`default_nettype none

module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(DATA_BITS);

  logic fall;
  logic data_sync;

  ps2_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .fall_pulse (fall),
    .data_sync  (data_sync)
  );

  rx_state_t            state;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [TW-1:0]        tmo_cnt;
  logic                 push;
  logic [7:0]           push_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      tmo_cnt     <= '0;
      push        <= 1'b0;
      push_data   <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      push        <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      if (state != IDLE && !fall) begin
        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state       <= IDLE;
          timeout_err <= 1'b1;
          tmo_cnt     <= '0;
          shreg       <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end else begin
        tmo_cnt <= '0;
        if (fall) begin
          case (state)
            IDLE: begin
              if (!data_sync) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                frame_err <= 1'b1;
              end
            end
            DATA: begin
              shreg   <= {data_sync, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == BW'(DATA_BITS - 1)) state <= PARITY;
            end
            PARITY: begin
              par_bit <= data_sync;
              state   <= STOP;
            end
            STOP: begin
              state <= IDLE;
              // A bad stop bit masks any parity problem in the same frame.
              if (!data_sync) begin
                frame_err <= 1'b1;
              end else if (!odd_ones(shreg, par_bit)) begin
                parity_err <= 1'b1;
              end else begin
                push      <= 1'b1;
                push_data <= shreg;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [PW:0]   count;
  logic [PW:0]   remain;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign out_valid = (count != '0);
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign do_pop    = out_valid & out_ready;
  assign do_push   = push & (~full | do_pop);
  assign remain    = count - (PW+1)'(do_pop);
  assign rd_next   = rd_ptr + PW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // out_data is registered so it can hold the last byte once the FIFO drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~do_pop;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      count  <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      if (remain == '0) begin
        if (do_push) out_data <= push_data;
      end else begin
        out_data <= mem[rd_next];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx.sv
// ==== tb_ps2_rx : scoreboard bench for ps2_rx with a frame-level reference model | rev 1.0 ====
`default_nettype none

module tb_ps2_rx;

  localparam int FILT  = 8;
  localparam int TMO   = 300;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;
  logic       overflow;

  ps2_rx #(.FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int exp_par = 0, exp_frm = 0, exp_tmo = 0, exp_ovf = 0;
  int n_par = 0, n_frm = 0, n_tmo = 0, n_ovf = 0, n_valid = 0;
  int ready_mode = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (parity_err)  n_par++;
      if (frame_err)   n_frm++;
      if (timeout_err) n_tmo++;
      if (overflow)    n_ovf++;
      if (out_valid)   n_valid++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_byte", int'(out_data), -1);
        else check_eq("byte_order", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  // Reference model: classify the whole 11-bit frame from the protocol rules.
  task automatic model_frame(input logic [10:0] f);
    if (f[10] == 1'b0) exp_frm++;
    else if ($countones(f[9:1]) % 2 == 0) exp_par++;
    else if (ready_mode == 0 && exp_q.size() >= DEPTH) exp_ovf++;
    else exp_q.push_back(f[8:1]);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    model_frame(f);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_parity_err"},  n_par, exp_par);
    check_eq({tag, "_frame_err"},   n_frm, exp_frm);
    check_eq({tag, "_timeout_err"}, n_tmo, exp_tmo);
    check_eq({tag, "_overflow"},    n_ovf, exp_ovf);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_data"},  int'(out_data), 0);
    check_eq({tag, "_flags"},
             int'({out_valid, parity_err, frame_err, timeout_err, overflow}), 0);
  endtask

  int v0;

  initial begin
    repeat (5) @(posedge clk);
    #1 check_reset_outputs("reset_held");
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_reset_outputs("after_reset");

    // Good frame with ready held high: exactly one valid cycle.
    ready_mode = 1;
    repeat (3) @(posedge clk);
    v0 = n_valid;
    send_frame(8'h1C, 1'b0, 1'b0);
    check_eq("good_1C_valid_cycles", n_valid - v0, 1);
    check_eq("good_1C_drained", exp_q.size(), 0);
    check_counts("good_1C");

    v0 = n_valid;
    send_frame(8'h1C, 1'b1, 1'b0);
    check_eq("badpar_1C_valid_cycles", n_valid - v0, 0);
    check_counts("badpar_1C");

    send_frame(8'hA5, 1'b1, 1'b1);
    check_counts("badstop_and_par");

    // A lone falling edge with data high is a bad start bit.
    ps2_bit(1'b1);
    repeat (HALF) @(posedge clk);
    exp_frm++;
    check_counts("bad_start");

    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    repeat (2 * TMO) @(posedge clk);
    exp_tmo++;
    check_counts("timeout");
    send_frame(8'hF0, 1'b0, 1'b0);
    check_eq("after_timeout_F0_drained", exp_q.size(), 0);
    check_counts("after_timeout");

    ready_mode = 0;
    repeat (3) @(posedge clk);
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b0, 1'b0);
      check_eq($sformatf("overflow_after_%0d", b), n_ovf, exp_ovf);
    end
    @(negedge clk);
    check_eq("full_head", int'(out_data), 1);
    check_eq("full_valid", int'(out_valid), 1);
    ready_mode = 1;
    repeat (20) @(posedge clk);
    check_eq("overflow_drained", exp_q.size(), 0);
    @(negedge clk);
    check_eq("empty_valid", int'(out_valid), 0);
    check_eq("empty_holds_last", int'(out_data), 4);
    check_counts("overflow");

    // Reset in the middle of a frame.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    @(negedge clk);
    reset_n = 1'b0;
    #1 check_reset_outputs("mid_frame_reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h5A, 1'b0, 1'b0);
    check_eq("after_reset_5A_drained", exp_q.size(), 0);
    check_counts("after_mid_reset");

    // Two-cycle glitch on ps2_clk with data low must not start a frame.
    ps2_data = 1'b0;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (30) @(posedge clk);
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h3C, 1'b0, 1'b0);
    check_eq("after_glitch_drained", exp_q.size(), 0);
    check_counts("glitch");

    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      send_frame(8'($urandom_range(0, 255)),
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0);
    end
    ready_mode = 1;
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge clk);
    check_eq("random_drained", exp_q.size(), 0);
    check_counts("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
